// File: rtl/rx_frame_sequencer.sv
// Frame assembler behind the UART RX byte selector: SYNC, CMD, LEN, PAYLOAD[LEN], CHK.
// A verified frame is held for the command interpreter until accepted; framing faults pulse an error.
module rx_frame_sequencer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CLK = 104160
) (
  input  logic       clk_b_selector,
  input  logic       rst_b_selector,
  input  logic       in_byte_en,
  input  logic [7:0] in_byte,
  input  logic       in_cmd_ready,
  input  logic [3:0] in_rd_addr,
  output logic       out_cmd_valid,
  output logic [7:0] out_cmd,
  output logic [3:0] out_len,
  output logic [7:0] out_rd_data,
  output logic       out_busy,
  output logic       out_err_chk,
  output logic       out_err_len,
  output logic       out_err_tmo,
  output logic       out_err_ovr
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_HOLD
  } state_t;

  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  // The error edge is the one on which the idle count would reach TIMEOUT_CLK-1.
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CLK - 2);

  state_t             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [7:0]         chk_q, chk_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         idx_q, idx_d;
  logic [31:0]        timer_q, timer_d;
  logic               err_chk_q, err_chk_d;
  logic               err_len_q, err_len_d;
  logic               err_tmo_q, err_tmo_d;
  logic               err_ovr_q, err_ovr_d;
  logic [7:0]         buf_q [MAX_LEN];
  logic [7:0]         buf_d [MAX_LEN];
  logic [MAX_LEN-1:0] buf_we;
  logic               timing;
  logic               tmo_hit;

  assign timing  = (state_q == S_CMD) || (state_q == S_LEN) ||
                   (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // A strobe in the final count cycle wins over the timeout.
  assign tmo_hit = timing && !in_byte_en && (timer_q == TMO_LAST);

  // State register
  always_ff @(posedge clk_b_selector or posedge rst_b_selector) begin
    if (rst_b_selector) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_byte_en && (in_byte == SYNC_BYTE)) state_d = S_CMD;
      S_CMD:     if (in_byte_en) state_d = S_LEN;
      S_LEN: begin
        if (in_byte_en) begin
          if (in_byte > MAX_LEN_B)  state_d = S_IDLE;
          else if (in_byte == 8'd0) state_d = S_CHK;
          else                      state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (in_byte_en && (idx_q == len_q - 4'd1)) state_d = S_CHK;
      S_CHK:     if (in_byte_en) state_d = (in_byte == chk_q) ? S_HOLD : S_IDLE;
      S_HOLD:    if (in_cmd_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
  end

  // Datapath and error-pulse next values
  always_comb begin
    cmd_d     = cmd_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    timer_d   = (timing && !in_byte_en && !tmo_hit) ? timer_q + 32'd1 : 32'd0;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_ovr_d = 1'b0;
    err_tmo_d = tmo_hit;
    if (in_byte_en) begin
      case (state_q)
        S_IDLE: begin
          if (in_byte == SYNC_BYTE) begin
            chk_d = 8'd0;
            idx_d = 4'd0;
          end
        end
        S_CMD: begin
          cmd_d = in_byte;
          chk_d = in_byte;
        end
        S_LEN: begin
          if (in_byte > MAX_LEN_B) begin
            err_len_d = 1'b1;
          end else begin
            len_d = in_byte[3:0];
            chk_d = chk_q ^ in_byte;
          end
        end
        S_PAYLOAD: begin
          chk_d = chk_q ^ in_byte;
          idx_d = idx_q + 4'd1;
        end
        S_CHK:   err_chk_d = (in_byte != chk_q);
        S_HOLD:  err_ovr_d = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_buf_we
    assign buf_we[gi] = (state_q == S_PAYLOAD) && in_byte_en && (idx_q == 4'(gi));
  end

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      buf_d[i] = buf_we[i] ? in_byte : buf_q[i];
    end
  end

  always_ff @(posedge clk_b_selector or posedge rst_b_selector) begin
    if (rst_b_selector) begin
      cmd_q     <= 8'd0;
      chk_q     <= 8'd0;
      len_q     <= 4'd0;
      idx_q     <= 4'd0;
      timer_q   <= 32'd0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= 8'd0;
    end else begin
      cmd_q     <= cmd_d;
      chk_q     <= chk_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= buf_d[i];
    end
  end

  // Output logic
  always_comb begin
    out_busy      = (state_q != S_IDLE);
    out_cmd_valid = (state_q == S_HOLD);
    out_rd_data   = 8'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (in_rd_addr == 4'(i)) out_rd_data = buf_q[i];
    end
  end

  assign out_cmd     = cmd_q;
  assign out_len     = len_q;
  assign out_err_chk = err_chk_q;
  assign out_err_len = err_len_q;
  assign out_err_tmo = err_tmo_q;
  assign out_err_ovr = err_ovr_q;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Bench for rx_frame_sequencer: directed frame table, random frames against a frame-level model,
// and hand-written timeout, overrun and reset sequences.
module tb_rx_frame_sequencer;
  localparam int TMO  = 20;
  localparam int MAXL = 8;
  localparam int K_OK = 0, K_CHK = 1, K_LEN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] byt = 8'd0;
  logic       rdy = 1'b0;
  logic [3:0] addr = 4'd0;
  logic       valid, busy, e_chk, e_len, e_tmo, e_ovr;
  logic [7:0] cmd, rd;
  logic [3:0] len;

  rx_frame_sequencer #(.SYNC_BYTE(8'hAA), .MAX_LEN(MAXL), .TIMEOUT_CLK(TMO)) dut (
    .clk_b_selector(clk), .rst_b_selector(rst), .in_byte_en(en), .in_byte(byt),
    .in_cmd_ready(rdy), .in_rd_addr(addr), .out_cmd_valid(valid), .out_cmd(cmd),
    .out_len(len), .out_rd_data(rd), .out_busy(busy), .out_err_chk(e_chk),
    .out_err_len(e_len), .out_err_tmo(e_tmo), .out_err_ovr(e_ovr));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int c_ovr = 0, c_err = 0;

  // Pulse counters, sampled once per clock on the falling edge
  always @(negedge clk) begin
    if (e_ovr) c_ovr++;
    if (e_chk || e_len || e_tmo || e_ovr) c_err++;
  end

  typedef struct {
    int          n;
    int          off;
    logic [95:0] bytes;
    int          kind;
    logic [7:0]  cmd;
    logic [3:0]  len;
  } vec_t;
  vec_t tab[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] vbyte(input logic [95:0] b, input int n, input int i);
    logic [95:0] t;
    t = b >> (8 * (n - 1 - i));
    return t[7:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    en  = 1'b1;
    byt = b;
    @(negedge clk);
    en  = 1'b0;
  endtask

  task automatic gstrobe(input logic [7:0] b);
    idle($urandom_range(0, 3));
    strobe(b);
  endtask

  task automatic check_payload(input string tag, input logic [7:0] pl[16], input int n);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      if (i < n)          check({tag, "_rd"}, rd, pl[i]);
      else if (i >= MAXL) check({tag, "_rd_oob"}, rd, 8'd0);
    end
    addr = 4'd0;
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    check({tag, "_valid_after_ready"}, valid, 1'b0);
    check({tag, "_busy_after_ready"}, busy, 1'b0);
  endtask

  // Called at the falling edge right after the checksum / LEN strobe was clocked in
  task automatic expect_outcome(input string tag, input int kind, input logic [7:0] ecmd,
                                input logic [3:0] elen, input logic [7:0] pl[16]);
    if (kind == K_OK) begin
      check({tag, "_valid"}, valid, 1'b1);
      check({tag, "_cmd"}, cmd, ecmd);
      check({tag, "_len"}, len, elen);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_no_err"}, {e_chk, e_len, e_tmo, e_ovr}, 4'b0);
      check_payload(tag, pl, int'(elen));
      idle($urandom_range(0, 2));
      check({tag, "_valid_held"}, valid, 1'b1);
      accept(tag);
    end else begin
      check({tag, "_err"}, {e_chk, e_len}, (kind == K_CHK) ? 2'b10 : 2'b01);
      check({tag, "_err_valid"}, valid, 1'b0);
      check({tag, "_err_busy"}, busy, 1'b0);
      @(negedge clk);
      check({tag, "_err_one_pulse"}, {e_chk, e_len}, 2'b00);
    end
  endtask

  task automatic send_t1();
    strobe(8'hAA); strobe(8'h10); strobe(8'h02);
    strobe(8'h33); strobe(8'h44); strobe(8'h65);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[16];
    logic [7:0] t1pl[16];
    logic [7:0] rcmd, rlen, rchk, b;
    int kind, first, base, ebase;

    foreach (t1pl[i]) t1pl[i] = 8'd0;
    t1pl[0] = 8'h33;
    t1pl[1] = 8'h44;

    tab[0] = '{6,  0, 96'hAA1002334465, K_OK, 8'h10, 4'd2};
    tab[1] = '{6,  0, 96'hAA1002334466, K_CHK, 8'h00, 4'd0};
    tab[2] = '{6,  0, 96'hAA1002334465, K_OK, 8'h10, 4'd2};
    tab[3] = '{3,  0, 96'hAA1009, K_LEN, 8'h00, 4'd0};
    tab[4] = '{4,  0, 96'hAA200020, K_OK, 8'h20, 4'd0};
    tab[5] = '{5,  0, 96'hAA0501AAAE, K_OK, 8'h05, 4'd1};
    tab[6] = '{12, 0, 96'hAA0108010203040506070801, K_OK, 8'h01, 4'd8};
    tab[7] = '{5,  1, 96'h55AA100010, K_OK, 8'h10, 4'd0};
    tab[8] = '{3,  0, 96'hAA100F, K_LEN, 8'h00, 4'd0};

    // Reset state
    idle(2);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_len", {cmd, len}, 12'h0);
    check("rst_errs", {e_chk, e_len, e_tmo, e_ovr}, 4'b0);
    check("rst_rd", rd, 8'd0);
    rst = 1'b0;
    idle(2);

    // Directed frame table
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < tab[v].n; i++) strobe(vbyte(tab[v].bytes, tab[v].n, i));
      foreach (pl[i]) pl[i] = 8'd0;
      for (int i = 0; i < int'(tab[v].len); i++)
        pl[i] = vbyte(tab[v].bytes, tab[v].n, tab[v].off + 3 + i);
      expect_outcome($sformatf("vec%0d", v), tab[v].kind, tab[v].cmd, tab[v].len, pl);
    end

    // Random frames checked against a frame-level model
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hAA) b = 8'h55;
        gstrobe(b);
      end
      rcmd = 8'($urandom);
      rlen = (kind == K_LEN) ? 8'($urandom_range(9, 15)) : 8'($urandom_range(0, MAXL));
      gstrobe(8'hAA); gstrobe(rcmd); gstrobe(rlen);
      foreach (pl[i]) pl[i] = 8'd0;
      if (kind != K_LEN) begin
        rchk = rcmd ^ rlen;
        for (int i = 0; i < int'(rlen); i++) begin
          pl[i] = 8'($urandom);
          rchk ^= pl[i];
          gstrobe(pl[i]);
        end
        if (kind == K_CHK) rchk ^= 8'($urandom_range(1, 255));
        gstrobe(rchk);
      end
      expect_outcome($sformatf("rnd%0d", f), kind, rcmd, rlen[3:0], pl);
    end

    // Timeout: pulse on the (TMO-1)th clock after the last strobe
    strobe(8'hAA); strobe(8'h10);
    first = -1;
    for (int j = 1; j <= TMO + 3; j++) begin
      @(negedge clk);
      if (e_tmo && first < 0) first = j;
    end
    check("tmo_latency", first, TMO - 1);
    check("tmo_idle", busy, 1'b0);

    // Strobe on the final count cycle prevents the timeout
    #1 ebase = c_err;
    strobe(8'hAA); strobe(8'h10);
    idle(TMO - 3);
    strobe(8'h00);
    check("tmo_last_no_pulse", e_tmo, 1'b0);
    check("tmo_last_busy", busy, 1'b1);
    idle(3);
    #1 check("tmo_last_no_errs", c_err - ebase, 0);
    strobe(8'h10);
    foreach (pl[i]) pl[i] = 8'd0;
    expect_outcome("tmo_last", K_OK, 8'h10, 4'd0, pl);

    // Overrun while a frame is held
    send_t1();
    check("ovr_valid", valid, 1'b1);
    #1 base = c_ovr;
    for (int k = 0; k < 5; k++) strobe(8'($urandom));
    idle(1);
    #1 check("ovr_count", c_ovr - base, 5);
    check("ovr_cmd", cmd, 8'h10);
    check("ovr_len", len, 4'd2);
    check("ovr_valid_held", valid, 1'b1);
    check_payload("ovr", t1pl, 2);
    @(negedge clk);
    rdy = 1'b1; en = 1'b1; byt = 8'hAA;
    @(negedge clk);
    rdy = 1'b0; en = 1'b0;
    check("ovr_ready_valid", valid, 1'b0);
    check("ovr_ready_pulse", e_ovr, 1'b1);
    check("ovr_ready_busy", busy, 1'b0);
    @(negedge clk);
    check("ovr_ready_one_pulse", e_ovr, 1'b0);

    // Reset in the middle of a frame
    #1 ebase = c_err;
    strobe(8'hAA); strobe(8'h10); strobe(8'h02); strobe(8'h33);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", {valid, busy, cmd, len}, 14'h0);
    check("mid_rst_errs", {e_chk, e_len, e_tmo, e_ovr}, 4'b0);
    check("mid_rst_rd", rd, 8'd0);
    rst = 1'b0;
    idle(2);
    #1 check("mid_rst_no_errs", c_err - ebase, 0);
    send_t1();
    expect_outcome("post_rst", K_OK, 8'h10, 4'd2, t1pl);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
